multicycle_control_unit: RTL and testbench

- Multi-cycle sequencer for the RV32I core.
- Fetches each instruction into an internal instruction register and classifies it into the core's instruction-format code (R/I/S/B/U/J/N), which drives the immediate builder.
- Steps the datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK with one-hot-free encoded control strobes.
- Handshakes with the instruction and data memories.

---
 rtl/multicycle_control_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the RV32I core
//
// Ports:
//   clk, rst                 clock (rising edge) and synchronous active-high reset
//   imem_req/ready/rdata     instruction fetch handshake and returned word
//   ir, instr_type           latched instruction and its format code (0=R 1=I 2=S 3=B 4=U 5=J 7=N)
//   branch_cond              ALU compare result for the current branch
//   pc_we, pc_sel, pc_init   PC write strobe, next-PC source, reset PC constant
//   alu_a_sel, alu_b_sel     ALU operand selects (A: 0=rs1 1=PC, B: 0=rs2 1=imm)
//   dmem_req/we/ready        data access handshake (we=1 store)
//   reg_we, wb_sel           register write strobe and write-back source
//   trap, state_dbg          sticky trap flag and current state encoding
module multicycle_control_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [2:0]  instr_type,
  input  logic        branch_cond,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [31:0] pc_init,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_TRAP    = 3'd7;

  localparam logic [2:0] T_R = 3'd0;
  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4;
  localparam logic [2:0] T_J = 3'd5;
  localparam logic [2:0] T_N = 3'd7;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // Count value seen on the last tolerated wait cycle; a further miss traps.
  localparam logic [15:0] TMO_LAST = (MEM_TIMEOUT == 0) ? 16'd0 : 16'(MEM_TIMEOUT - 1);

  function automatic logic [2:0] decode_type(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_LUI, OP_AUIPC:  decode_type = T_U;
      OP_JAL:            decode_type = T_J;
      OP_JALR:           decode_type = (f3 == 3'b000) ? T_I : T_N;
      OP_LOAD, OP_IMM:   decode_type = T_I;
      OP_STORE:          decode_type = T_S;
      OP_BRANCH:         decode_type = T_B;
      OP_OP:             decode_type = T_R;
      default:           decode_type = T_N;
    endcase
  endfunction

  logic [2:0]  state;
  logic [15:0] tmo_cnt;
  logic [2:0]  dec_type;
  logic        is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic        req_wait, tmo_hit;

  assign dec_type  = decode_type(ir[6:0], ir[14:12]);
  assign is_load   = (ir[6:0] == OP_LOAD);
  assign is_store  = (ir[6:0] == OP_STORE);
  assign is_branch = (ir[6:0] == OP_BRANCH);
  assign is_jal    = (ir[6:0] == OP_JAL);
  assign is_jalr   = (ir[6:0] == OP_JALR);
  assign is_lui    = (ir[6:0] == OP_LUI);
  assign is_auipc  = (ir[6:0] == OP_AUIPC);

  // A request is waiting when it is on the bus and ready has not come back.
  assign req_wait = ((state == S_FETCH) && imem_req && !imem_ready) ||
                    ((state == S_MEM) && !dmem_ready);
  assign tmo_hit  = (MEM_TIMEOUT != 0) && req_wait && (tmo_cnt == TMO_LAST);

  // imem_req is a register so the cycle right after reset has every strobe low;
  // it is raised on every transition into FETCH, so normal fetches lose no cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      ir         <= 32'h0;
      instr_type <= T_N;
      trap       <= 1'b0;
      tmo_cnt    <= 16'd0;
      imem_req   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ready) begin
            ir       <= imem_rdata;
            state    <= S_DECODE;
            imem_req <= 1'b0;
            tmo_cnt  <= 16'd0;
          end else if (tmo_hit) begin
            state    <= S_TRAP;
            trap     <= 1'b1;
            imem_req <= 1'b0;
            tmo_cnt  <= 16'd0;
          end else begin
            imem_req <= 1'b1;
            if (imem_req) tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_DECODE: begin
          instr_type <= dec_type;
          if (dec_type == T_N) begin
            state <= S_TRAP;
            trap  <= 1'b1;
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          if (is_load || is_store) begin
            state <= S_MEM;
          end else if (is_branch) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            tmo_cnt <= 16'd0;
            if (is_store) begin
              state    <= S_FETCH;
              imem_req <= 1'b1;
            end else begin
              state <= S_WB;
            end
          end else if (tmo_hit) begin
            state   <= S_TRAP;
            trap    <= 1'b1;
            tmo_cnt <= 16'd0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_TRAP: begin
          state <= S_TRAP;
        end
        default: begin
          state <= S_TRAP;
          trap  <= 1'b1;
        end
      endcase
    end
  end

  // Control strobes decoded from state and ir. The store's PC update is the one
  // place that follows dmem_ready directly, since it must land in the completing cycle.
  always_comb begin
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    case (state)
      S_EXECUTE: begin
        alu_a_sel = is_auipc || is_jal || is_branch;
        alu_b_sel = !((instr_type == T_R) || (instr_type == T_B));
        if (is_branch) begin
          pc_we  = 1'b1;
          pc_sel = branch_cond ? 2'd1 : 2'd0;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        pc_we    = is_store && dmem_ready;
      end
      S_WB: begin
        pc_we  = 1'b1;
        reg_we = (ir[11:7] != 5'd0);
        if (is_load)                wb_sel = 2'd1;
        else if (is_jal || is_jalr) wb_sel = 2'd2;
        else if (is_lui)            wb_sel = 2'd3;
        if (is_jal)       pc_sel = 2'd1;
        else if (is_jalr) pc_sel = 2'd2;
      end
      default: ;
    endcase
  end

  assign pc_init   = RESET_PC;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  localparam int          TMO  = 16;
  localparam logic [31:0] RPC  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ir;
  logic [2:0]  instr_type;
  logic        branch_cond = 1'b0;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [31:0] pc_init;
  logic        alu_a_sel, alu_b_sel;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [2:0]  state_dbg;

  multicycle_control_unit #(.RESET_PC(RPC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .ir(ir), .instr_type(instr_type), .branch_cond(branch_cond),
    .pc_we(pc_we), .pc_sel(pc_sel), .pc_init(pc_init),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One expected cycle: inputs to apply and outputs required.
  typedef struct {
    logic       im_rdy, dm_rdy;
    logic [2:0] st;
    logic       imr, dmr, dmw, pcw, rgw, aa, ab, tr;
    logic [1:0] pcs, wbs;
    logic       chk;
    logic [2:0] ty;
  } cyc_t;

  cyc_t        q[$];
  logic [31:0] cur;
  logic [2:0]  cur_ty;

  function automatic logic [2:0] classify(input logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17: return 3'd4;                          // LUI, AUIPC
      7'h6F:        return 3'd5;                          // JAL
      7'h67:        return (i[14:12] == 3'd0) ? 3'd1 : 3'd7; // JALR
      7'h03, 7'h13: return 3'd1;                          // LOAD, OP-IMM
      7'h23:        return 3'd2;                          // STORE
      7'h63:        return 3'd3;                          // BRANCH
      7'h33:        return 3'd0;                          // OP
      default:      return 3'd7;
    endcase
  endfunction

  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c = '{default: '0};
    c.st     = st;
    c.im_rdy = 1'($urandom);
    c.dm_rdy = 1'($urandom);
    return c;
  endfunction

  function automatic logic [15:0] pack(input cyc_t c);
    return {1'b0, c.st, c.imr, c.dmr, c.dmw, c.pcw, c.rgw, c.pcs, c.wbs, c.aa, c.ab, c.tr};
  endfunction

  task automatic trap_tail(input int n, input logic chk);
    cyc_t c;
    for (int k = 0; k < n; k++) begin
      c = blank(3'd7);
      c.tr = 1'b1; c.chk = chk; c.ty = cur_ty;
      q.push_back(c);
    end
  endtask

  // Expected trace of one instruction from its first FETCH cycle, derived from the
  // phase rules: fetch waits, 1 decode, 1 execute, optional memory waits, 1 writeback.
  task automatic build(input logic [31:0] instr, input int iw, input int dw,
                       input logic bc, input int tail);
    cyc_t c;
    logic [6:0] op;
    logic ld, sto, br, jal, jalr, lui, auipc;
    op = instr[6:0];
    ld = (op == 7'h03); sto = (op == 7'h23); br = (op == 7'h63);
    jal = (op == 7'h6F); jalr = (op == 7'h67); lui = (op == 7'h37); auipc = (op == 7'h17);
    cur = instr;
    cur_ty = classify(instr);
    q.delete();
    for (int k = 0; k < ((iw >= TMO) ? TMO : iw); k++) begin
      c = blank(3'd0); c.imr = 1'b1; c.im_rdy = 1'b0;
      q.push_back(c);
    end
    if (iw >= TMO) begin
      trap_tail(tail, 1'b0);
      return;
    end
    c = blank(3'd0); c.imr = 1'b1; c.im_rdy = 1'b1;
    q.push_back(c);
    q.push_back(blank(3'd1));
    if (cur_ty == 3'd7) begin
      trap_tail(tail, 1'b1);
      return;
    end
    c = blank(3'd2);
    c.chk = 1'b1; c.ty = cur_ty;
    c.aa = auipc || jal || br;
    c.ab = !(cur_ty == 3'd0 || cur_ty == 3'd3);
    if (br) begin c.pcw = 1'b1; c.pcs = {1'b0, bc}; end
    q.push_back(c);
    if (ld || sto) begin
      for (int k = 0; k < ((dw >= TMO) ? TMO : dw); k++) begin
        c = blank(3'd3); c.dmr = 1'b1; c.dmw = sto; c.dm_rdy = 1'b0;
        c.chk = 1'b1; c.ty = cur_ty;
        q.push_back(c);
      end
      if (dw >= TMO) begin
        trap_tail(tail, 1'b1);
        return;
      end
      c = blank(3'd3); c.dmr = 1'b1; c.dmw = sto; c.dm_rdy = 1'b1; c.pcw = sto;
      c.chk = 1'b1; c.ty = cur_ty;
      q.push_back(c);
    end
    if (br || sto) return;
    c = blank(3'd4);
    c.chk = 1'b1; c.ty = cur_ty;
    c.pcw = 1'b1;
    c.rgw = (instr[11:7] != 5'd0);
    c.wbs = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
    c.pcs = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
    q.push_back(c);
  endtask

  task automatic run_q(output logic trapped);
    trapped = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      imem_ready = q[i].im_rdy;
      dmem_ready = q[i].dm_rdy;
      imem_rdata = (q[i].st == 3'd0 && q[i].im_rdy) ? cur : $urandom;
      #1;
      check($sformatf("cyc%0d_op%h", i, cur[6:0]),
            {16'h0, 1'b0, state_dbg, imem_req, dmem_req, dmem_we, pc_we, reg_we,
             pc_sel, wb_sel, alu_a_sel, alu_b_sel, trap},
            {16'h0, pack(q[i])});
      if (q[i].chk) begin
        check("instr_type", {29'h0, instr_type}, {29'h0, q[i].ty});
        check("ir", ir, cur);
      end
      if (q[i].st == 3'd7) trapped = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    check("rst_state", {29'h0, state_dbg}, 32'd0);
    check("rst_strobes", {27'h0, imem_req, dmem_req, dmem_we, pc_we, reg_we}, 32'd0);
    check("rst_sels", {26'h0, pc_sel, wb_sel, alu_a_sel, alu_b_sel}, 32'd0);
    check("rst_trap", {31'h0, trap}, 32'd0);
    check("rst_type", {29'h0, instr_type}, 32'd7);
    check("rst_ir", ir, 32'd0);
    check("pc_init", pc_init, RPC);
  endtask

  task automatic do_instr(input logic [31:0] instr, input int iw, input int dw,
                          input logic bc, input int tail);
    logic t;
    branch_cond = bc;
    build(instr, iw, dw, bc, tail);
    run_q(t);
    if (t) do_reset();
  endtask

  logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h33, 7'h13};
  logic [31:0] ri;
  logic        dummy;

  initial begin
    do_reset();
    // Directed cases.
    do_instr(32'h00500093, 0, 0, 1'b0, 3);   // addi x1,x0,5
    do_instr(32'h0000A103, 1, 3, 1'b0, 3);   // lw x2,0(x1), dmem delayed 3
    do_instr(32'h00208463, 0, 0, 1'b1, 3);   // beq taken
    do_instr(32'h00208463, 2, 0, 1'b0, 3);   // beq not taken
    do_instr(32'h008000EF, 0, 0, 1'b0, 3);   // jal
    do_instr(32'h000080E7, 0, 0, 1'b1, 3);   // jalr
    do_instr(32'h00112223, 0, 0, 1'b0, 3);   // sw, zero wait
    do_instr(32'h00112223, 1, 2, 1'b0, 3);   // sw, dmem delayed 2
    do_instr(32'h123450B7, 0, 0, 1'b0, 3);   // lui
    do_instr(32'h00001117, 0, 0, 1'b0, 3);   // auipc
    do_instr(32'h002081B3, 0, 0, 1'b0, 3);   // add
    do_instr(32'h00000013, 0, 0, 1'b0, 3);   // nop: rd=0 so no reg write
    do_instr(32'h0000A103, TMO - 1, TMO - 1, 1'b0, 3); // ready on the last allowed cycle
    do_instr(32'h000090E7, 0, 0, 1'b0, 3);   // jalr with funct3!=0 is illegal
    do_instr(32'hFFFFFFFF, 0, 0, 1'b0, 20);  // illegal, sticky for 20 cycles
    do_instr(32'h00500093, TMO, 0, 1'b0, 3); // imem never ready
    do_instr(32'h0000A103, 0, TMO, 1'b0, 3); // dmem never ready
    // Reset arriving while a load waits in MEM.
    branch_cond = 1'b0;
    build(32'h0000A103, 0, 100, 1'b0, 3);
    q = q[0:4];
    run_q(dummy);
    do_reset();
    // Randomized mix.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        ri = $urandom;
      end else begin
        ri = $urandom;
        ri[6:0] = ops[$urandom_range(0, 8)];
        if (ri[6:0] == 7'h67 && $urandom_range(0, 3) != 0) ri[14:12] = 3'd0;
      end
      do_instr(ri,
               ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 3)),
               1'($urandom), 3);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
